// File: rtl/mdr_load_ctrl.sv
// Memory-load controller: one word-aligned bus read per load, result latched into the MDR.
// Optional MDR_TIMEOUT_EN aborts a read that sees no mem_ack within TIMEOUT_CYCLES cycles.
module mdr_load_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [1:0]  ld_size,
  output logic [31:0] mem_addr,
  output logic        mem_stb,
  input  logic        mem_ack,
  input  logic [31:0] mem_din,
  output logic [31:0] mdr_out,
  output logic [1:0]  mdr_pos,
  output logic        busy,
  output logic        ld_done,
  output logic        ld_err
);
  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  state_t state, state_nxt;
  logic   req_ok, tmo;
  logic   stb_nxt, done_nxt, err_nxt, accept, capture;

  always_comb begin
    req_ok = 1'b1;
    case (ld_size)
      2'b01:   req_ok = ~ld_addr[0];
      2'b10:   req_ok = (ld_addr[1:0] == 2'b00);
      2'b11:   req_ok = 1'b0;
      default: req_ok = 1'b1;
    endcase
  end

`ifdef MDR_TIMEOUT_EN
  // Terminal at TIMEOUT_CYCLES-1 so the abort lands on the edge the count would reach TIMEOUT_CYCLES.
  localparam logic [7:0] TERM = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             wait_cnt <= '0;
    else if (state != REQ)  wait_cnt <= '0;
    else if (!mem_ack)      wait_cnt <= wait_cnt + 8'd1;
  end

  assign tmo = (wait_cnt == TERM);
`else
  localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    stb_nxt   = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (ld_req) begin
          if (req_ok) begin
            state_nxt = REQ;
            stb_nxt   = 1'b1;
            accept    = 1'b1;
          end else begin
            state_nxt = ERR;
          end
        end
      end
      REQ: begin
        // ack beats a coincident timeout
        if (mem_ack) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
          capture   = 1'b1;
        end else if (tmo) begin
          state_nxt = ERR;
        end else begin
          stb_nxt   = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      ERR: begin
        state_nxt = IDLE;
        err_nxt   = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mem_stb  <= 1'b0;
      busy     <= 1'b0;
      ld_done  <= 1'b0;
      ld_err   <= 1'b0;
      mem_addr <= '0;
      mdr_out  <= '0;
      mdr_pos  <= '0;
    end else begin
      state   <= state_nxt;
      mem_stb <= stb_nxt;
      busy    <= (state_nxt != IDLE);
      ld_done <= done_nxt;
      ld_err  <= err_nxt;
      if (accept) begin
        mem_addr <= {ld_addr[31:2], 2'b00};
        mdr_pos  <= ld_addr[1:0];
      end
      if (capture) mdr_out <= mem_din;
    end
  end

endmodule

// File: tb/tb_mdr_load_ctrl.sv
// Randomized self-checking bench for mdr_load_ctrl against a transaction-level load model.
module tb_mdr_load_ctrl;
`ifdef MDR_TIMEOUT_EN
  localparam int TB_TO = 4;
`else
  localparam int TB_TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_req = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [1:0]  ld_size = '0;
  logic [31:0] mem_addr;
  logic        mem_stb;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_din = '0;
  logic [31:0] mdr_out;
  logic [1:0]  mdr_pos;
  logic        busy, ld_done, ld_err;

  int tests = 0;
  int fails = 0;

  // reference state: what MDR and position should hold
  logic [31:0] exp_mdr = '0;
  logic [1:0]  exp_pos = '0;

  // observations from the last transaction
  int obs_stb, obs_done, obs_err, obs_done_at, obs_err_at, obs_addr_bad, obs_both;

  always #5 clk = ~clk;

  mdr_load_ctrl #(.TIMEOUT_CYCLES(TB_TO)) dut (
    .clk(clk), .rst_n(rst_n), .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size),
    .mem_addr(mem_addr), .mem_stb(mem_stb), .mem_ack(mem_ack), .mem_din(mem_din),
    .mdr_out(mdr_out), .mdr_pos(mdr_pos), .busy(busy), .ld_done(ld_done), .ld_err(ld_err)
  );

  function automatic bit legal(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'b11) return 1'b0;
    if (sz == 2'b01 && a[0]) return 1'b0;
    if (sz == 2'b10 && a[1:0] != 2'b00) return 1'b0;
    return 1'b1;
  endfunction

  // n = strobe cycle during which ack is returned (0 = never); poke re-asserts ld_req mid-transfer
  task automatic run_load(input logic [31:0] a, input logic [1:0] sz, input int n,
                          input logic [31:0] d, input bit poke);
    int len;
    len = (n == 0) ? 24 : n + 10;
    obs_stb = 0; obs_done = 0; obs_err = 0; obs_done_at = -1; obs_err_at = -1;
    obs_addr_bad = 0; obs_both = 0;
    @(negedge clk);
    ld_req = 1'b1; ld_addr = a; ld_size = sz;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (c == 0) ld_req = 1'b0;
      if (poke && c == 1) begin ld_req = 1'b1; ld_addr = $urandom & 32'hFFFF_FFFC; ld_size = 2'b10; end
      if (poke && c == 2) ld_req = 1'b0;
      if (mem_stb) begin
        obs_stb++;
        if (mem_addr !== {a[31:2], 2'b00}) obs_addr_bad = 1;
        if (obs_stb == n) begin mem_ack = 1'b1; mem_din = d; end
      end
      if (ld_done) begin obs_done++; obs_done_at = c; end
      if (ld_err) begin obs_err++; obs_err_at = c; end
      if (ld_done && ld_err) obs_both = 1;
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if ({mem_stb, busy, ld_done, ld_err} !== 4'b0) begin
      fails++; $display("FAIL reset_ctl: got %b want 0000", {mem_stb, busy, ld_done, ld_err});
    end
    tests++;
    if ({mdr_out, mem_addr, mdr_pos} !== 66'b0) begin
      fails++; $display("FAIL reset_data: mdr %h addr %h pos %b want zeros", mdr_out, mem_addr, mdr_pos);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_word_load();
    run_load(32'h0000_1004, 2'b10, 1, 32'hDEAD_BEEF, 1'b0);
    exp_mdr = 32'hDEAD_BEEF; exp_pos = 2'b00;
    tests++;
    if (mem_addr !== 32'h0000_1004 || obs_addr_bad != 0) begin
      fails++; $display("FAIL word_addr: got %h want 00001004", mem_addr);
    end
    tests++;
    if (mdr_out !== exp_mdr || mdr_pos !== exp_pos) begin
      fails++; $display("FAIL word_mdr: got %h/%b want %h/%b", mdr_out, mdr_pos, exp_mdr, exp_pos);
    end
    tests++;
    if (obs_done != 1 || obs_done_at != 1 || obs_stb != 1 || obs_err != 0) begin
      fails++; $display("FAIL word_timing: done %0d@%0d stb %0d err %0d want 1@1 1 0",
                        obs_done, obs_done_at, obs_stb, obs_err);
    end
  endtask

  task automatic test_half_wait();
    run_load(32'h0000_2002, 2'b01, 6, 32'h1234_5678, 1'b0);
    if (6 <= TB_TO) begin exp_mdr = 32'h1234_5678; exp_pos = 2'b10; end
    tests++;
    if (obs_stb != ((6 <= TB_TO) ? 6 : TB_TO) || obs_addr_bad != 0 || mem_addr !== 32'h0000_2000) begin
      fails++; $display("FAIL half_stb: cycles %0d addr %h", obs_stb, mem_addr);
    end
    tests++;
    if (mdr_out !== exp_mdr || mdr_pos !== exp_pos) begin
      fails++; $display("FAIL half_mdr: got %h/%b want %h/%b", mdr_out, mdr_pos, exp_mdr, exp_pos);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] addrs [2];
    logic [1:0]  sizes [2];
    addrs[0] = 32'h0000_0003; sizes[0] = 2'b10;
    addrs[1] = 32'h0000_0001; sizes[1] = 2'b01;
    for (int i = 0; i < 2; i++) begin
      run_load(addrs[i], sizes[i], 1, $urandom, 1'b0);
      tests++;
      if (obs_err != 1 || obs_err_at != 1 || obs_stb != 0 || obs_done != 0) begin
        fails++; $display("FAIL misalign%0d: err %0d@%0d stb %0d done %0d want 1@1 0 0",
                          i, obs_err, obs_err_at, obs_stb, obs_done);
      end
      tests++;
      if (mdr_out !== exp_mdr || mdr_pos !== exp_pos) begin
        fails++; $display("FAIL misalign%0d_mdr: got %h/%b want %h/%b", i, mdr_out, mdr_pos, exp_mdr, exp_pos);
      end
    end
  endtask

  task automatic test_ignored();
    logic [31:0] d;
    d = $urandom;
    run_load(32'h0000_3000, 2'b10, 3, d, 1'b1);
    exp_mdr = d; exp_pos = 2'b00;
    tests++;
    if (obs_stb != 3 || obs_done != 1) begin
      fails++; $display("FAIL ign_req: stb %0d done %0d want 3 1", obs_stb, obs_done);
    end
    @(negedge clk); mem_ack = 1'b1; mem_din = ~d;
    @(negedge clk); mem_ack = 1'b0;
    tests++;
    if (mdr_out !== exp_mdr || mem_stb !== 1'b0 || busy !== 1'b0 || ld_done !== 1'b0) begin
      fails++; $display("FAIL ign_ack: mdr %h stb %b busy %b want %h 0 0", mdr_out, mem_stb, busy, exp_mdr);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); ld_req = 1'b1; ld_addr = 32'h0000_4000; ld_size = 2'b10;
    @(negedge clk); ld_req = 1'b0;
    tests++;
    if (mem_stb !== 1'b1) begin fails++; $display("FAIL rmid_stb: got %b want 1", mem_stb); end
    #2 rst_n = 1'b0;
    #1;
    exp_mdr = '0; exp_pos = '0;
    tests++;
    if (mem_stb !== 1'b0 || busy !== 1'b0 || mdr_out !== 32'h0) begin
      fails++; $display("FAIL rmid_async: stb %b busy %b mdr %h want 0 0 0", mem_stb, busy, mdr_out);
    end
    @(negedge clk); rst_n = 1'b1;
    run_load(32'h0000_5008, 2'b10, 2, 32'hCAFE_F00D, 1'b0);
    exp_mdr = 32'hCAFE_F00D;
    tests++;
    if (mdr_out !== exp_mdr || obs_done != 1 || obs_stb != 2) begin
      fails++; $display("FAIL rmid_fresh: mdr %h done %0d stb %0d want %h 1 2", mdr_out, obs_done, obs_stb, exp_mdr);
    end
  endtask

  task automatic test_wait_limit();
`ifdef MDR_TIMEOUT_EN
    run_load(32'h0000_6000, 2'b10, 0, 32'h0, 1'b0);
    tests++;
    if (obs_stb != TB_TO || obs_err != 1 || obs_err_at != TB_TO + 1 || obs_done != 0) begin
      fails++; $display("FAIL tmo: stb %0d err %0d@%0d done %0d want %0d 1@%0d 0",
                        obs_stb, obs_err, obs_err_at, obs_done, TB_TO, TB_TO + 1);
    end
    tests++;
    if (mdr_out !== exp_mdr) begin fails++; $display("FAIL tmo_mdr: got %h want %h", mdr_out, exp_mdr); end
    run_load(32'h0000_6004, 2'b10, TB_TO, 32'h5A5A_A5A5, 1'b0);
    exp_mdr = 32'h5A5A_A5A5; exp_pos = 2'b00;
    tests++;
    if (obs_done != 1 || obs_err != 0 || mdr_out !== exp_mdr) begin
      fails++; $display("FAIL tmo_edge: done %0d err %0d mdr %h want 1 0 %h", obs_done, obs_err, mdr_out, exp_mdr);
    end
`else
    run_load(32'h0000_6000, 2'b10, 20, 32'h5A5A_A5A5, 1'b0);
    exp_mdr = 32'h5A5A_A5A5; exp_pos = 2'b00;
    tests++;
    if (obs_stb != 20 || obs_done_at != 20 || obs_err != 0 || mdr_out !== exp_mdr) begin
      fails++; $display("FAIL long_wait: stb %0d done@%0d err %0d mdr %h want 20 20 0 %h",
                        obs_stb, obs_done_at, obs_err, mdr_out, exp_mdr);
    end
`endif
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic [1:0]  sz;
    int          n;
    bit          ok, to, poke;
    for (int i = 0; i < 40; i++) begin
      a = $urandom; sz = 2'($urandom_range(0, 3)); d = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      n = $urandom_range(1, (TB_TO < 255) ? TB_TO + 3 : 6);
      ok = legal(a, sz);
      to = ok && (n > TB_TO);
      poke = ok && ($urandom_range(0, 3) == 0);
      run_load(a, sz, n, d, poke);
      if (ok && !to) begin exp_mdr = d; exp_pos = a[1:0]; end
      tests++;
      if (obs_stb != (!ok ? 0 : (to ? TB_TO : n)) || obs_addr_bad != 0) begin
        fails++; $display("FAIL rnd%0d_stb: cycles %0d addr_bad %0d (a %h sz %b n %0d)", i, obs_stb, obs_addr_bad, a, sz, n);
      end
      tests++;
      if (obs_done != ((ok && !to) ? 1 : 0) || obs_err != ((ok && !to) ? 0 : 1) || obs_both != 0) begin
        fails++; $display("FAIL rnd%0d_pulse: done %0d err %0d both %0d (a %h sz %b n %0d)", i, obs_done, obs_err, obs_both, a, sz, n);
      end
      tests++;
      if (mdr_out !== exp_mdr || mdr_pos !== exp_pos || busy !== 1'b0) begin
        fails++; $display("FAIL rnd%0d_mdr: got %h/%b busy %b want %h/%b", i, mdr_out, mdr_pos, busy, exp_mdr, exp_pos);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_half_wait();
    test_misaligned();
    test_ignored();
    test_reset_mid();
    test_wait_limit();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
